// File: rtl/fetch_decode_queue_if.sv
// Fetch-to-decode queue handshake bundle: dual enqueue slots from fetch, dual dequeue slots to decode.
// master = fetch/decode side driving the queue, slave = the queue itself.
interface fetch_decode_queue_if #(
    parameter int PC_WIDTH              = 39,
    parameter int EXCEPTION_CAUSE_WIDTH = 4
);
    logic                             flush_i;

    logic                             enq_first_vld_i;
    logic [PC_WIDTH-1:0]              enq_first_pc_i;
    logic [PC_WIDTH-1:0]              enq_first_next_pc_i;
    logic [PC_WIDTH-1:0]              enq_first_predict_pc_i;
    logic [31:0]                      enq_first_instr_i;
    logic                             enq_first_is_rv_i;
    logic                             enq_first_excp_vld_i;
    logic [EXCEPTION_CAUSE_WIDTH-1:0] enq_first_ecause_i;

    logic                             enq_second_vld_i;
    logic [PC_WIDTH-1:0]              enq_second_pc_i;
    logic [PC_WIDTH-1:0]              enq_second_next_pc_i;
    logic [PC_WIDTH-1:0]              enq_second_predict_pc_i;
    logic [31:0]                      enq_second_instr_i;
    logic                             enq_second_is_rv_i;
    logic                             enq_second_excp_vld_i;
    logic [EXCEPTION_CAUSE_WIDTH-1:0] enq_second_ecause_i;

    logic                             enq_rdy_o;

    logic                             deq_first_vld_o;
    logic [PC_WIDTH-1:0]              deq_first_pc_o;
    logic [PC_WIDTH-1:0]              deq_first_next_pc_o;
    logic [PC_WIDTH-1:0]              deq_first_predict_pc_o;
    logic [31:0]                      deq_first_instr_o;
    logic                             deq_first_is_rv_o;
    logic                             deq_first_excp_vld_o;
    logic [EXCEPTION_CAUSE_WIDTH-1:0] deq_first_ecause_o;
    logic                             deq_first_rdy_i;

    logic                             deq_second_vld_o;
    logic [PC_WIDTH-1:0]              deq_second_pc_o;
    logic [PC_WIDTH-1:0]              deq_second_next_pc_o;
    logic [PC_WIDTH-1:0]              deq_second_predict_pc_o;
    logic [31:0]                      deq_second_instr_o;
    logic                             deq_second_is_rv_o;
    logic                             deq_second_excp_vld_o;
    logic [EXCEPTION_CAUSE_WIDTH-1:0] deq_second_ecause_o;
    logic                             deq_second_rdy_i;

    logic                             empty_o;
    logic                             full_o;

    modport master (
        output flush_i,
        output enq_first_vld_i, enq_first_pc_i, enq_first_next_pc_i, enq_first_predict_pc_i,
               enq_first_instr_i, enq_first_is_rv_i, enq_first_excp_vld_i, enq_first_ecause_i,
        output enq_second_vld_i, enq_second_pc_i, enq_second_next_pc_i, enq_second_predict_pc_i,
               enq_second_instr_i, enq_second_is_rv_i, enq_second_excp_vld_i, enq_second_ecause_i,
        input  enq_rdy_o,
        input  deq_first_vld_o, deq_first_pc_o, deq_first_next_pc_o, deq_first_predict_pc_o,
               deq_first_instr_o, deq_first_is_rv_o, deq_first_excp_vld_o, deq_first_ecause_o,
        output deq_first_rdy_i,
        input  deq_second_vld_o, deq_second_pc_o, deq_second_next_pc_o, deq_second_predict_pc_o,
               deq_second_instr_o, deq_second_is_rv_o, deq_second_excp_vld_o, deq_second_ecause_o,
        output deq_second_rdy_i,
        input  empty_o, full_o
    );

    modport slave (
        input  flush_i,
        input  enq_first_vld_i, enq_first_pc_i, enq_first_next_pc_i, enq_first_predict_pc_i,
               enq_first_instr_i, enq_first_is_rv_i, enq_first_excp_vld_i, enq_first_ecause_i,
        input  enq_second_vld_i, enq_second_pc_i, enq_second_next_pc_i, enq_second_predict_pc_i,
               enq_second_instr_i, enq_second_is_rv_i, enq_second_excp_vld_i, enq_second_ecause_i,
        output enq_rdy_o,
        output deq_first_vld_o, deq_first_pc_o, deq_first_next_pc_o, deq_first_predict_pc_o,
               deq_first_instr_o, deq_first_is_rv_o, deq_first_excp_vld_o, deq_first_ecause_o,
        input  deq_first_rdy_i,
        output deq_second_vld_o, deq_second_pc_o, deq_second_next_pc_o, deq_second_predict_pc_o,
               deq_second_instr_o, deq_second_is_rv_o, deq_second_excp_vld_o, deq_second_ecause_o,
        input  deq_second_rdy_i,
        output empty_o, full_o
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// Dual-in/dual-out instruction queue between fetch and decode; flush drops all entries.
// Optional FDQ_PERF_CNT_EN adds saturating stall and flushed-entry counters.
module fetch_decode_queue #(
    parameter int PC_WIDTH              = 39,
    parameter int EXCEPTION_CAUSE_WIDTH = 4,
    parameter int FDQ_DEPTH             = 8,
    parameter int FDQ_PTR_WIDTH         = $clog2(FDQ_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_decode_queue_if.slave  fdq
`ifdef FDQ_PERF_CNT_EN
   ,output logic [31:0]          perf_stall_cnt_o,
    output logic [31:0]          perf_flush_cnt_o
`endif
);
    typedef struct packed {
        logic [PC_WIDTH-1:0]              pc;
        logic [PC_WIDTH-1:0]              next_pc;
        logic [PC_WIDTH-1:0]              predict_pc;
        logic [31:0]                      instr;
        logic                             is_rv;
        logic                             excp_vld;
        logic [EXCEPTION_CAUSE_WIDTH-1:0] ecause;
    } entry_t;

    localparam logic [FDQ_PTR_WIDTH-1:0] PTR_ONE = FDQ_PTR_WIDTH'(1);
    localparam logic [FDQ_PTR_WIDTH-1:0] PTR_TWO = FDQ_PTR_WIDTH'(2);
    localparam logic [FDQ_PTR_WIDTH:0]   CNT_RDY = (FDQ_PTR_WIDTH+1)'(FDQ_DEPTH-2);
    localparam logic [FDQ_PTR_WIDTH:0]   CNT_MAX = (FDQ_PTR_WIDTH+1)'(FDQ_DEPTH);
    localparam logic [FDQ_PTR_WIDTH:0]   CNT_ONE = (FDQ_PTR_WIDTH+1)'(1);
    localparam logic [FDQ_PTR_WIDTH:0]   CNT_TWO = (FDQ_PTR_WIDTH+1)'(2);

    entry_t                   mem [FDQ_DEPTH];
    logic [FDQ_PTR_WIDTH-1:0] head, tail, head_p1, tail_p1;
    logic [FDQ_PTR_WIDTH:0]   count, n_enq, n_deq;
    logic                     enq_rdy, do_enq, pop0, pop1;
    entry_t                   enq0, enq1, rd0, rd1;

    assign head_p1 = head + PTR_ONE;
    assign tail_p1 = tail + PTR_ONE;

    assign enq0 = '{fdq.enq_first_pc_i, fdq.enq_first_next_pc_i, fdq.enq_first_predict_pc_i,
                    fdq.enq_first_instr_i, fdq.enq_first_is_rv_i, fdq.enq_first_excp_vld_i,
                    fdq.enq_first_ecause_i};
    assign enq1 = '{fdq.enq_second_pc_i, fdq.enq_second_next_pc_i, fdq.enq_second_predict_pc_i,
                    fdq.enq_second_instr_i, fdq.enq_second_is_rv_i, fdq.enq_second_excp_vld_i,
                    fdq.enq_second_ecause_i};

    // Ready is judged on the registered count only, so fetch never depends on decode's ready.
    assign enq_rdy = (count <= CNT_RDY);
    assign do_enq  = enq_rdy & ~fdq.flush_i;

    always_comb begin
        n_enq = '0;
        if (do_enq) begin
            if (fdq.enq_first_vld_i && fdq.enq_second_vld_i)      n_enq = CNT_TWO;
            else if (fdq.enq_first_vld_i || fdq.enq_second_vld_i) n_enq = CNT_ONE;
        end
    end

    assign pop0  = (count >= CNT_ONE) & fdq.deq_first_rdy_i;
    assign pop1  = pop0 & (count >= CNT_TWO) & fdq.deq_second_rdy_i;
    assign n_deq = pop1 ? CNT_TWO : (pop0 ? CNT_ONE : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (fdq.flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= pop1 ? head + PTR_TWO : (pop0 ? head_p1 : head);
            tail  <= tail + n_enq[FDQ_PTR_WIDTH-1:0];
            count <= count + n_enq - n_deq;
        end
    end

    // Payload storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            if (fdq.enq_first_vld_i) begin
                mem[tail] <= enq0;
                if (fdq.enq_second_vld_i) mem[tail_p1] <= enq1;
            end else if (fdq.enq_second_vld_i) begin
                mem[tail] <= enq1;
            end
        end
    end

    assign rd0 = mem[head];
    assign rd1 = mem[head_p1];

    assign fdq.enq_rdy_o        = enq_rdy;
    assign fdq.empty_o          = (count == '0);
    assign fdq.full_o           = (count == CNT_MAX);
    assign fdq.deq_first_vld_o  = (count >= CNT_ONE);
    assign fdq.deq_second_vld_o = (count >= CNT_TWO);

    assign fdq.deq_first_pc_o          = rd0.pc;
    assign fdq.deq_first_next_pc_o     = rd0.next_pc;
    assign fdq.deq_first_predict_pc_o  = rd0.predict_pc;
    assign fdq.deq_first_instr_o       = rd0.instr;
    assign fdq.deq_first_is_rv_o       = rd0.is_rv;
    assign fdq.deq_first_excp_vld_o    = rd0.excp_vld;
    assign fdq.deq_first_ecause_o      = rd0.ecause;
    assign fdq.deq_second_pc_o         = rd1.pc;
    assign fdq.deq_second_next_pc_o    = rd1.next_pc;
    assign fdq.deq_second_predict_pc_o = rd1.predict_pc;
    assign fdq.deq_second_instr_o      = rd1.instr;
    assign fdq.deq_second_is_rv_o      = rd1.is_rv;
    assign fdq.deq_second_excp_vld_o   = rd1.excp_vld;
    assign fdq.deq_second_ecause_o     = rd1.ecause;

`ifdef FDQ_PERF_CNT_EN
    logic [32:0] flush_sum;
    assign flush_sum = {1'b0, perf_flush_cnt_o} + 33'(count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            if ((fdq.enq_first_vld_i | fdq.enq_second_vld_i) && !enq_rdy &&
                (perf_stall_cnt_o != 32'hFFFF_FFFF))
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            if (fdq.flush_i)
                perf_flush_cnt_o <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
        end
    end
`endif
endmodule
